uart_core: RTL

- Parametrised successor to the board's fixed 9600-baud 8N1 serial block: full-duplex UART, one clock domain, no derived clocks.
- Generic divider from clock/baud parameters; configurable data bits, parity and stop bits.
- RX uses 3-sample majority vote and reports frame, parity and overrun errors. TX takes bytes over a valid/ready handshake.
- Internal loopback mode for board self-test. Sits between host-link logic and the FPGA rxd/txd pins.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_if.sv | 24 ++
 rtl/uart_baud_gen.sv | 24 ++
 rtl/uart_core.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared encodings, FSM state types and helpers for uart_core
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Clocks per oversample tick, rounded to nearest and never below 1.
  function automatic int div_calc(input int clk_hz, input int baud, input int ovs);
    int d;
    d = (clk_hz + (baud * ovs) / 2) / (baud * ovs);
    return (d < 1) ? 1 : d;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_if.sv
// rtl/uart_if.sv - host-side TX/RX handshake bundle for uart_core
interface uart_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ack;
  logic                 rx_parity_err;
  logic                 rx_frame_err;
  logic                 rx_overrun;

  modport master (
    output tx_data, tx_valid, rx_ack,
    input  tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );

  modport slave (
    input  tx_data, tx_valid, rx_ack,
    output tx_ready, rx_data, rx_valid, rx_parity_err, rx_frame_err, rx_overrun
  );
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - free-running divider, one-clock tick every DIV clocks
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);
  localparam int            CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign tick = (cnt_q == CNT_LAST);
endmodule

// File: rtl/uart_core.sv
// rtl/uart_core.sv - full-duplex UART: handshaked TX, majority-vote RX with error flags
module uart_core
  import uart_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int BAUD      = 9600,
  parameter int OVS       = 8,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic   clk,
  input  logic   rst,
  uart_if.slave  bus,
  output logic   txd,
  input  logic   rxd,
  input  logic   loopback
);
  localparam int            DIV      = div_calc(CLK_HZ, BAUD, OVS);
  localparam int            BIT_CLKS = DIV * OVS;
  localparam int            BW       = $clog2(BIT_CLKS);
  localparam int            TW       = $clog2(OVS);
  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_CLKS - 1);
  localparam logic [TW-1:0] T_S0     = TW'(OVS / 2 - 1);
  localparam logic [TW-1:0] T_S1     = TW'(OVS / 2);
  localparam logic [TW-1:0] T_S2     = TW'(OVS / 2 + 1);
  localparam logic [TW-1:0] T_LAST   = TW'(OVS - 1);
  localparam logic [2:0]    D_LAST   = 3'(DATA_BITS - 1);
  localparam logic [2:0]    S_LAST   = 3'(STOP_BITS - 1);
  localparam logic          ODD      = (PARITY == PAR_ODD);

  tx_state_e            tx_state_q, tx_state_d;
  logic [BW-1:0]        tx_cnt_q, tx_cnt_d;
  logic [2:0]           tx_idx_q, tx_idx_d;
  logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
  logic                 tx_par_q, tx_par_d;
  logic                 tx_line;
  logic                 tx_bit_end;

  assign tx_bit_end = (tx_cnt_q == BIT_LAST);

  // Bit timing uses its own counter so TX edges are exact regardless of tick phase.
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_idx_d   = tx_idx_q;
    tx_shift_d = tx_shift_q;
    tx_par_d   = tx_par_q;
    tx_line    = 1'b1;
    if (tx_state_q != TX_IDLE) tx_cnt_d = tx_bit_end ? '0 : tx_cnt_q + 1'b1;
    case (tx_state_q)
      TX_IDLE: begin
        if (bus.tx_valid) begin
          tx_state_d = TX_START;
          tx_shift_d = bus.tx_data;
          tx_par_d   = (^bus.tx_data) ^ ODD;
        end
      end
      TX_START: begin
        tx_line = 1'b0;
        if (tx_bit_end) begin
          tx_state_d = TX_DATA;
          tx_idx_d   = '0;
        end
      end
      TX_DATA: begin
        tx_line = tx_shift_q[0];
        if (tx_bit_end) begin
          tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
          if (tx_idx_q == D_LAST) begin
            tx_state_d = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
            tx_idx_d   = '0;
          end else begin
            tx_idx_d = tx_idx_q + 1'b1;
          end
        end
      end
      TX_PARITY: begin
        tx_line = tx_par_q;
        if (tx_bit_end) tx_state_d = TX_STOP;
      end
      TX_STOP: begin
        if (tx_bit_end) begin
          if (tx_idx_q == S_LAST) tx_state_d = TX_IDLE;
          else                    tx_idx_d   = tx_idx_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_idx_q   <= '0;
      tx_shift_q <= '0;
      tx_par_q   <= 1'b0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_idx_q   <= tx_idx_d;
      tx_shift_q <= tx_shift_d;
      tx_par_q   <= tx_par_d;
    end
  end

  assign bus.tx_ready = (tx_state_q == TX_IDLE);
  assign txd          = loopback ? 1'b1 : tx_line;

  logic                 tick;
  logic                 sync1_q, sync2_q;
  rx_state_e            rx_state_q, rx_state_d;
  logic [TW-1:0]        rx_tcnt_q, rx_tcnt_d;
  logic [2:0]           rx_idx_q, rx_idx_d;
  logic [DATA_BITS-1:0] rx_word_q, rx_word_d;
  logic [1:0]           rx_smp_q, rx_smp_d;
  logic                 rx_perr_f_q, rx_perr_f_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rx_perr_q, rx_perr_d;
  logic                 rx_ferr_q, rx_ferr_d;
  logic                 rx_ovr_q, rx_ovr_d;
  logic                 rx_bit, rx_done, rx_ferr_now;

  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  assign rx_bit = maj3(rx_smp_q[0], rx_smp_q[1], sync2_q);

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tcnt_d   = rx_tcnt_q;
    rx_idx_d    = rx_idx_q;
    rx_word_d   = rx_word_q;
    rx_smp_d    = rx_smp_q;
    rx_perr_f_d = rx_perr_f_q;
    rx_done     = 1'b0;
    rx_ferr_now = 1'b0;
    if (tick) begin
      if (rx_state_q == RX_IDLE) begin
        if (!sync2_q) begin
          rx_state_d  = RX_START;
          rx_tcnt_d   = '0;
          rx_perr_f_d = 1'b0;
        end
      end else begin
        rx_tcnt_d = (rx_tcnt_q == T_LAST) ? '0 : rx_tcnt_q + 1'b1;
        if (rx_tcnt_q == T_S0) rx_smp_d[0] = sync2_q;
        if (rx_tcnt_q == T_S1) rx_smp_d[1] = sync2_q;
        case (rx_state_q)
          RX_START: begin
            if (rx_tcnt_q == T_S2 && rx_bit) begin
              rx_state_d = RX_IDLE;
            end else if (rx_tcnt_q == T_LAST) begin
              rx_state_d = RX_DATA;
              rx_idx_d   = '0;
            end
          end
          RX_DATA: begin
            if (rx_tcnt_q == T_S2) rx_word_d = {rx_bit, rx_word_q[DATA_BITS-1:1]};
            if (rx_tcnt_q == T_LAST) begin
              if (rx_idx_q == D_LAST) begin
                rx_state_d = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
                rx_idx_d   = '0;
              end else begin
                rx_idx_d = rx_idx_q + 1'b1;
              end
            end
          end
          RX_PARITY: begin
            if (rx_tcnt_q == T_S2) rx_perr_f_d = rx_bit ^ (^rx_word_q) ^ ODD;
            if (rx_tcnt_q == T_LAST) rx_state_d = RX_STOP;
          end
          RX_STOP: begin
            // Leave on the first stop sample so an early next start edge is caught.
            if (rx_tcnt_q == T_S2) begin
              rx_state_d  = RX_IDLE;
              rx_done     = 1'b1;
              rx_ferr_now = ~rx_bit;
            end
          end
          default: rx_state_d = RX_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    rx_perr_d  = rx_perr_q;
    rx_ferr_d  = rx_ferr_q;
    rx_ovr_d   = rx_ovr_q;
    if (rx_done) begin
      rx_data_d  = rx_word_q;
      rx_valid_d = 1'b1;
      rx_perr_d  = rx_perr_f_q;
      rx_ferr_d  = rx_ferr_now;
      rx_ovr_d   = rx_valid_q & ~bus.rx_ack;
    end else if (bus.rx_ack && rx_valid_q) begin
      rx_valid_d = 1'b0;
      rx_ovr_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_tcnt_q   <= '0;
      rx_idx_q    <= '0;
      rx_word_q   <= '0;
      rx_smp_q    <= '0;
      rx_perr_f_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      rx_perr_q   <= 1'b0;
      rx_ferr_q   <= 1'b0;
      rx_ovr_q    <= 1'b0;
    end else begin
      sync1_q     <= loopback ? tx_line : rxd;
      sync2_q     <= sync1_q;
      rx_state_q  <= rx_state_d;
      rx_tcnt_q   <= rx_tcnt_d;
      rx_idx_q    <= rx_idx_d;
      rx_word_q   <= rx_word_d;
      rx_smp_q    <= rx_smp_d;
      rx_perr_f_q <= rx_perr_f_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      rx_perr_q   <= rx_perr_d;
      rx_ferr_q   <= rx_ferr_d;
      rx_ovr_q    <= rx_ovr_d;
    end
  end

  assign bus.rx_data       = rx_data_q;
  assign bus.rx_valid      = rx_valid_q;
  assign bus.rx_parity_err = rx_perr_q;
  assign bus.rx_frame_err  = rx_ferr_q;
  assign bus.rx_overrun    = rx_ovr_q;
endmodule
